// File: rtl/uart_wishbone_master_if.sv
// Wishbone bus bundle for uart_wishbone_master.
// The master modport drives the cycle; the slave modport returns termination and read data.
interface uart_wishbone_master_if #(
  parameter int ADDR_WIDTH = 23
);
  logic                  cyc_o;
  logic                  stb_o;
  logic                  we_o;
  logic [ADDR_WIDTH-1:0] adr_o;
  logic [7:0]            dat_o;
  logic                  ack_i;
  logic                  err_i;
  logic                  rty_i;
  logic [7:0]            dat_i;

  modport master (
    output cyc_o, stb_o, we_o, adr_o, dat_o,
    input  ack_i, err_i, rty_i, dat_i
  );

  modport slave (
    input  cyc_o, stb_o, we_o, adr_o, dat_o,
    output ack_i, err_i, rty_i, dat_i
  );
endinterface

// File: rtl/uart_wishbone_master.sv
// UART (8N1) to Wishbone bridge: a host sends CMD, address and write data
// bytes; the bridge runs single or burst Wishbone cycles and replies over TX.
// Optional feature macro UART_WB_STATUS_EN: status byte after every command
// and abort of the remaining burst on the first non-ack termination.
module uart_wishbone_master #(
  parameter int CLKS_PER_BIT   = 16,
  parameter int ADDR_WIDTH     = 23,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   uart_rxd,
  output logic                   uart_txd,
  uart_wishbone_master_if.master wb
);
  localparam int ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
  localparam int AB_W       = ADDR_BYTES * 8;
  localparam int TMR_W      = $clog2(TIMEOUT_CYCLES + 1);
`ifdef UART_WB_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {IDLE, ADDR, WR_DATA, WR_WB, RD_WB, RD_TX, STATUS_TX} state_t;

  logic            rxd_meta, rxd_sync, rxd_prev;
  rx_state_t       rx_state;
  logic [7:0]      rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift;
  logic            rx_done, rx_ferr;

  logic            tx_start;
  logic [7:0]      tx_byte;
  logic            tx_busy, tx_done;
  logic [7:0]      tx_cnt;
  logic [3:0]      tx_bit;
  logic [8:0]      tx_shift;

  state_t          state;
  logic            byte_pend;
  logic [7:0]      byte_buf;
  logic            wr;
  logic [6:0]      len_m1, beat;
  logic [2:0]      addr_idx;
  logic [ADDR_WIDTH-1:0] base;
  logic [AB_W-1:0] base_next;
  logic [TMR_W-1:0] timer;
  logic [1:0]      status, term_code, first_status;
  logic            term, aborted;
  logic            addr_unused;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= uart_rxd;
      rxd_sync <= rxd_meta;
      rxd_prev <= rxd_sync;
    end
  end

  // Receiver: start edge, mid-bit glitch re-check, then one sample per bit time.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx_done  <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      rx_ferr <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rxd_prev && !rxd_sync) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == 8'(CLKS_PER_BIT / 2 - 1)) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rxd_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 8'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == 8'(CLKS_PER_BIT - 1)) begin
            rx_cnt   <= '0;
            rx_shift <= {rxd_sync, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 8'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == 8'(CLKS_PER_BIT - 1)) begin
            rx_cnt   <= '0;
            rx_done  <= rxd_sync;
            rx_ferr  <= !rxd_sync;
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt + 8'd1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Transmitter: start bit, eight data bits LSB first, stop bit; done pulses at stop end.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      uart_txd <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '1;
    end else begin
      tx_done <= 1'b0;
      if (!tx_busy) begin
        if (tx_start) begin
          uart_txd <= 1'b0;
          tx_shift <= {1'b1, tx_byte};
          tx_busy  <= 1'b1;
          tx_cnt   <= '0;
          tx_bit   <= '0;
        end
      end else if (tx_cnt == 8'(CLKS_PER_BIT - 1)) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_busy <= 1'b0;
          tx_done <= 1'b1;
        end else begin
          uart_txd <= tx_shift[0];
          tx_shift <= {1'b1, tx_shift[8:1]};
          tx_bit   <= tx_bit + 4'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + 8'd1;
      end
    end
  end

  // Address assembly with the incoming byte, and termination decode (err > rty > ack > timeout).
  always_comb begin
    base_next = AB_W'(base);
    base_next[{addr_idx, 3'b000} +: 8] = byte_buf;
    term      = 1'b1;
    term_code = 2'd0;
    if (wb.err_i)                                   term_code = 2'd1;
    else if (wb.rty_i)                              term_code = 2'd2;
    else if (wb.ack_i)                              term_code = 2'd0;
    else if (timer == TMR_W'(TIMEOUT_CYCLES - 1))   term_code = 2'd3;
    else                                            term      = 1'b0;
    first_status = (status == 2'd0) ? term_code : status;
  end

  assign addr_unused = ^base_next;

  // Frame parser and Wishbone master; all bus outputs are registered here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      byte_pend <= 1'b0;
      byte_buf  <= '0;
      wr        <= 1'b0;
      len_m1    <= '0;
      beat      <= '0;
      addr_idx  <= '0;
      base      <= '0;
      timer     <= '0;
      status    <= '0;
      aborted   <= 1'b0;
      tx_start  <= 1'b0;
      tx_byte   <= '0;
      wb.cyc_o  <= 1'b0;
      wb.stb_o  <= 1'b0;
      wb.we_o   <= 1'b0;
      wb.adr_o  <= '0;
      wb.dat_o  <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (byte_pend) begin
            byte_pend <= 1'b0;
            wr        <= byte_buf[7];
            len_m1    <= byte_buf[6:0];
            beat      <= '0;
            addr_idx  <= '0;
            base      <= '0;
            status    <= '0;
            aborted   <= 1'b0;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (byte_pend) begin
            byte_pend <= 1'b0;
            base      <= base_next[ADDR_WIDTH-1:0];
            if (addr_idx == 3'(ADDR_BYTES - 1)) begin
              if (wr) begin
                state <= WR_DATA;
              end else begin
                wb.adr_o <= base_next[ADDR_WIDTH-1:0];
                wb.we_o  <= 1'b0;
                wb.cyc_o <= 1'b1;
                wb.stb_o <= 1'b1;
                timer    <= '0;
                state    <= RD_WB;
              end
            end else begin
              addr_idx <= addr_idx + 3'd1;
            end
          end
        end
        WR_DATA: begin
          if (byte_pend) begin
            byte_pend <= 1'b0;
            if (aborted) begin
              if (beat == len_m1) begin
                tx_start <= 1'b1;
                tx_byte  <= {6'd0, status};
                state    <= STATUS_TX;
              end else begin
                beat <= beat + 7'd1;
              end
            end else begin
              wb.dat_o <= byte_buf;
              wb.adr_o <= base + ADDR_WIDTH'(beat);
              wb.we_o  <= 1'b1;
              wb.cyc_o <= 1'b1;
              wb.stb_o <= 1'b1;
              timer    <= '0;
              state    <= WR_WB;
            end
          end
        end
        WR_WB: begin
          if (term) begin
            wb.cyc_o <= 1'b0;
            wb.stb_o <= 1'b0;
            status   <= first_status;
            if (beat == len_m1) begin
              tx_start <= 1'b1;
              tx_byte  <= STATUS_EN ? {6'd0, first_status} : 8'h00;
              state    <= STATUS_TX;
            end else begin
              beat    <= beat + 7'd1;
              aborted <= STATUS_EN && (term_code != 2'd0);
              state   <= WR_DATA;
            end
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        RD_WB: begin
          byte_pend <= 1'b0;
          if (term) begin
            wb.cyc_o <= 1'b0;
            wb.stb_o <= 1'b0;
            status   <= first_status;
            aborted  <= STATUS_EN && (term_code != 2'd0);
            tx_byte  <= (term_code == 2'd0) ? wb.dat_i : 8'h00;
            tx_start <= 1'b1;
            state    <= RD_TX;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        RD_TX: begin
          byte_pend <= 1'b0;
          if (tx_done) begin
            if (beat == len_m1 || aborted) begin
              if (STATUS_EN) begin
                tx_start <= 1'b1;
                tx_byte  <= {6'd0, status};
                state    <= STATUS_TX;
              end else begin
                state <= IDLE;
              end
            end else begin
              beat     <= beat + 7'd1;
              wb.adr_o <= base + ADDR_WIDTH'(beat + 7'd1);
              wb.cyc_o <= 1'b1;
              wb.stb_o <= 1'b1;
              timer    <= '0;
              state    <= RD_WB;
            end
          end
        end
        STATUS_TX: begin
          if (tx_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (rx_done && state != RD_WB && state != RD_TX) begin
        byte_pend <= 1'b1;
        byte_buf  <= rx_shift;
      end

      if (rx_ferr && (state == IDLE || state == ADDR || state == WR_DATA)) begin
        byte_pend <= 1'b0;
        wb.cyc_o  <= 1'b0;
        wb.stb_o  <= 1'b0;
        state     <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_uart_wishbone_master.sv
// Self-checking bench for uart_wishbone_master: a UART host, a Wishbone slave
// with per-beat scripted terminations, a TX byte decoder, and a frame-level
// reference model that predicts bus beats and reply bytes.
module tb_uart_wishbone_master;
  localparam int CPB = 16;
  localparam int AW  = 23;
  localparam int TO  = 64;
`ifdef UART_WB_STATUS_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  logic uart_txd;

  uart_wishbone_master_if #(.ADDR_WIDTH(AW)) wb_bus ();

  uart_wishbone_master #(
    .CLKS_PER_BIT(CPB),
    .ADDR_WIDTH(AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .uart_rxd(rxd),
    .uart_txd(uart_txd),
    .wb(wb_bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Slave script: kind 0 ack, 1 err, 2 rty, 3 never terminate, 4 err+rty+ack together.
  int         kind  [128];
  int         delay [128];
  logic [7:0] rdata [128];
  logic [7:0] fr_data [128];
  int         slave_beat = 0;

  logic [AW-1:0] log_adr [$];
  logic          log_we  [$];
  logic [7:0]    log_dat [$];
  int            log_hi  [$];
  logic [7:0]    tx_q    [$];
  int stab_err = 0;
  int cycstb_err = 0;
  int tx_stop_err = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Wishbone slave: logs each cycle, checks bus stability, answers per script at negedge.
  initial begin
    int w, cur, hi;
    bit prev;
    logic [AW-1:0] a0;
    logic we0;
    logic [7:0] d0;
    w = 0; cur = 0; hi = 0; prev = 1'b0; a0 = '0; we0 = 1'b0; d0 = '0;
    wb_bus.ack_i = 1'b0;
    wb_bus.err_i = 1'b0;
    wb_bus.rty_i = 1'b0;
    wb_bus.dat_i = 8'h00;
    forever begin
      @(negedge clk);
      if (wb_bus.cyc_o !== wb_bus.stb_o) cycstb_err++;
      wb_bus.ack_i = 1'b0;
      wb_bus.err_i = 1'b0;
      wb_bus.rty_i = 1'b0;
      if (wb_bus.cyc_o === 1'b1) begin
        if (!prev) begin
          cur = slave_beat & 127;
          slave_beat++;
          w = 0; hi = 0;
          a0 = wb_bus.adr_o; we0 = wb_bus.we_o; d0 = wb_bus.dat_o;
          log_adr.push_back(a0);
          log_we.push_back(we0);
          log_dat.push_back(d0);
        end else if (wb_bus.adr_o !== a0 || wb_bus.we_o !== we0 || wb_bus.dat_o !== d0) begin
          stab_err++;
        end
        hi++;
        if (w == delay[cur]) begin
          case (kind[cur])
            0: wb_bus.ack_i = 1'b1;
            1: wb_bus.err_i = 1'b1;
            2: wb_bus.rty_i = 1'b1;
            4: begin wb_bus.ack_i = 1'b1; wb_bus.err_i = 1'b1; wb_bus.rty_i = 1'b1; end
            default: ;
          endcase
          wb_bus.dat_i = rdata[cur];
        end
        w++;
        prev = 1'b1;
      end else begin
        if (prev) log_hi.push_back(hi);
        prev = 1'b0;
      end
    end
  end

  // TX decoder: samples mid-bit after each start edge and queues the byte.
  initial begin
    logic [7:0] b;
    b = '0;
    wait (rst == 1'b0);
    forever begin
      @(negedge uart_txd);
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = uart_txd;
      end
      repeat (CPB) @(negedge clk);
      if (uart_txd !== 1'b1) tx_stop_err++;
      tx_q.push_back(b);
    end
  end

  task automatic sendByte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic applyStimulus(input bit we, input int n, input logic [AW-1:0] addr);
    logic [23:0] a24;
    a24 = 24'(addr);
    sendByte({we, 7'(n - 1)}, 1'b1);
    for (int i = 0; i < 3; i++) sendByte(a24[8*i +: 8], 1'b1);
    if (we) for (int i = 0; i < n; i++) sendByte(fr_data[i], 1'b1);
  endtask

  task automatic setSlave(input int k, input int d);
    for (int i = 0; i < 128; i++) begin
      kind[i] = k; delay[i] = d; rdata[i] = 8'(i * 37 + 5);
    end
  endtask

  task automatic clearLogs();
    log_adr.delete(); log_we.delete(); log_dat.delete(); log_hi.delete();
    tx_q.delete();
    slave_beat = 0; stab_err = 0; cycstb_err = 0; tx_stop_err = 0;
  endtask

  // Runs one frame (optionally preceded by a CMD byte with a bad stop bit) and checks it.
  task automatic runFrame(input bit we, input int n, input logic [AW-1:0] addr, input bit pre_bad, input string tag);
    logic [AW-1:0] exp_adr [$];
    logic [7:0]    exp_dat [$];
    int            exp_hi  [$];
    logic [7:0]    exp_tx  [$];
    int status, code, budget;
    bit aborted;
    clearLogs();
    status = 0; aborted = 1'b0;
    for (int i = 0; i < n && !aborted; i++) begin
      exp_adr.push_back(addr + AW'(i));
      exp_dat.push_back(fr_data[i]);
      code = (kind[i] == 4) ? 1 : kind[i];
      exp_hi.push_back((kind[i] == 3) ? TO : delay[i] + 1);
      if (!we) exp_tx.push_back((code == 0) ? rdata[i] : 8'h00);
      if (status == 0) status = code;
      if (STATUS_EN && code != 0) aborted = 1'b1;
    end
    if (we || STATUS_EN) exp_tx.push_back(STATUS_EN ? 8'(status) : 8'h00);

    if (pre_bad) begin
      sendByte(8'h00, 1'b0);
      repeat (3 * CPB) @(negedge clk);
    end
    applyStimulus(we, n, addr);
    budget = 0;
    while (tx_q.size() < exp_tx.size() && budget < 6000) begin
      @(negedge clk);
      budget++;
    end
    repeat (12 * CPB) @(negedge clk);

    checkOutput({tag, "_reply_wait"}, 32'(budget < 6000), 32'd1);
    checkOutput({tag, "_nbeats"}, 32'(log_adr.size()), 32'(exp_adr.size()));
    for (int i = 0; i < exp_adr.size() && i < log_adr.size() && i < log_hi.size(); i++) begin
      checkOutput($sformatf("%s_adr%0d", tag, i), 32'(log_adr[i]), 32'(exp_adr[i]));
      checkOutput($sformatf("%s_we%0d", tag, i), 32'(log_we[i]), 32'(we));
      if (we) checkOutput($sformatf("%s_dat%0d", tag, i), 32'(log_dat[i]), 32'(exp_dat[i]));
      checkOutput($sformatf("%s_cyclen%0d", tag, i), 32'(log_hi[i]), 32'(exp_hi[i]));
    end
    checkOutput({tag, "_ntx"}, 32'(tx_q.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
      checkOutput($sformatf("%s_tx%0d", tag, i), 32'(tx_q[i]), 32'(exp_tx[i]));
    checkOutput({tag, "_bus_stable"}, 32'(stab_err), 32'd0);
    checkOutput({tag, "_cyc_eq_stb"}, 32'(cycstb_err), 32'd0);
    checkOutput({tag, "_tx_stop"}, 32'(tx_stop_err), 32'd0);
    checkOutput({tag, "_end_cyc"}, 32'(wb_bus.cyc_o), 32'd0);
    checkOutput({tag, "_end_txd"}, 32'(uart_txd), 32'd1);
  endtask

  initial begin
    bit rwe;
    int rn, r, budget;
    logic [AW-1:0] raddr;
    setSlave(0, 1);

    // Reset state
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("rst_txd", 32'(uart_txd), 32'd1);
    checkOutput("rst_cyc", 32'(wb_bus.cyc_o), 32'd0);
    checkOutput("rst_stb", 32'(wb_bus.stb_o), 32'd0);
    checkOutput("rst_we",  32'(wb_bus.we_o), 32'd0);
    checkOutput("rst_adr", 32'(wb_bus.adr_o), 32'd0);
    checkOutput("rst_dat", 32'(wb_bus.dat_o), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single write, ack after 2 cycles
    $display("[TB] write N=1");
    setSlave(0, 2);
    fr_data[0] = 8'hA5;
    runFrame(1'b1, 1, 23'h000123, 1'b0, "wr1");

    // Read burst wrapping past the top of the address space
    $display("[TB] read N=3 wrap");
    setSlave(0, 1);
    rdata[0] = 8'h11; rdata[1] = 8'h22; rdata[2] = 8'h33;
    runFrame(1'b0, 3, 23'h7FFFFF, 1'b0, "rd3");

    // Write burst with err on beat 0
    $display("[TB] write N=2 err");
    setSlave(0, 1);
    kind[0] = 1;
    fr_data[0] = 8'h5A; fr_data[1] = 8'hC3;
    runFrame(1'b1, 2, 23'h000040, 1'b0, "wr2err");

    // Read with no termination: timeout
    $display("[TB] read timeout");
    setSlave(3, 0);
    runFrame(1'b0, 1, 23'h001000, 1'b0, "rdto");

    // Simultaneous err/rty/ack resolves as err, then a plain ack beat
    $display("[TB] termination priority");
    setSlave(0, 0);
    kind[0] = 4;
    runFrame(1'b0, 2, 23'h002000, 1'b0, "prio");

    // Framing error on CMD, then valid frame
    $display("[TB] framing error");
    setSlave(0, 1);
    fr_data[0] = 8'h3C;
    runFrame(1'b1, 1, 23'h000777, 1'b1, "ferr");

    // Short glitch on rxd in idle is not a byte
    $display("[TB] glitch");
    clearLogs();
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (400) @(negedge clk);
    checkOutput("glitch_ntx", 32'(tx_q.size()), 32'd0);
    checkOutput("glitch_nbeats", 32'(log_adr.size()), 32'd0);
    setSlave(0, 0);
    fr_data[0] = 8'h99;
    runFrame(1'b1, 1, 23'h000010, 1'b0, "postglitch");

    // Randomized frames
    for (int f = 0; f < 6; f++) begin
      rwe = 1'($urandom_range(0, 1));
      rn = $urandom_range(1, 5);
      raddr = (f % 3 == 0) ? AW'(23'h7FFFFF - 23'($urandom_range(0, 3))) : AW'($urandom);
      for (int i = 0; i < rn; i++) begin
        fr_data[i] = 8'($urandom);
        rdata[i] = 8'($urandom);
        delay[i] = $urandom_range(0, 5);
        r = $urandom_range(0, 9);
        kind[i] = (r < 6) ? 0 : (r == 6) ? 1 : (r == 7) ? 2 : (r == 8) ? 4 : 3;
      end
      $display("[TB] random frame %0d we=%0d n=%0d", f, rwe, rn);
      runFrame(rwe, rn, raddr, 1'b0, $sformatf("rnd%0d", f));
    end

    // Reset while a cycle is open
    $display("[TB] reset mid-cycle");
    setSlave(3, 0);
    clearLogs();
    applyStimulus(1'b0, 1, 23'h000300);
    budget = 0;
    while (wb_bus.cyc_o !== 1'b1 && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("rstmid_cyc_seen", 32'(wb_bus.cyc_o), 32'd1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstmid_cyc", 32'(wb_bus.cyc_o), 32'd0);
    checkOutput("rstmid_txd", 32'(uart_txd), 32'd1);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    setSlave(0, 2);
    rdata[0] = 8'h6E;
    runFrame(1'b0, 1, 23'h000301, 1'b0, "postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_wishbone_master.md
UART_WISHBONE_MASTER -- requirements
Module: uart_wishbone_master

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk_i cycles per UART bit; legal range 8..255.
REQ-002 Parameter ADDR_WIDTH, default 23: Wishbone address width; legal range 1..32; ADDR_BYTES = ceil(ADDR_WIDTH/8).
REQ-003 Parameter TIMEOUT_CYCLES, default 64: maximum cycles cyc_o stays high without termination; legal range 1..(8*CLKS_PER_BIT - 4).
REQ-004 Ports:
- clk_i  in  1  clock; one clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- uart_rxd  in  1  asynchronous serial input, 8N1, LSB first.
- uart_txd  out  1  serial output, 8N1, LSB first.
- cyc_o, stb_o  out  1 each  Wishbone cycle/strobe; always equal.
- we_o  out  1  write enable.
- adr_o  out  ADDR_WIDTH  address.
- dat_o  out  8  write data.
- ack_i, err_i, rty_i  in  1 each  cycle terminations.
- dat_i  in  8  read data.

Function
REQ-005 uart_rxd SHALL pass through a 2-flop synchroniser before any use.
REQ-006 Receiver SHALL detect start on the falling edge, re-check low at CLKS_PER_BIT/2; if high, discard as a glitch; sample data bits every CLKS_PER_BIT thereafter.
REQ-007 A stop bit sampled low SHALL be a framing error: byte discarded and frame parser returned to IDLE.
REQ-008 Receiver SHALL run independently of the Wishbone/TX FSM and hold one completed byte; the parser SHALL consume it within one cycle in every state except RD_WB/RD_TX.
REQ-009 Frame: CMD byte (bit7 = we, bits[6:0] = N-1, burst length N = 1..128), then ADDR_BYTES address bytes LSB byte first, upper unused bits ignored; for writes, then N data bytes.
REQ-010 Parser states: IDLE, ADDR, WR_DATA, WR_WB, RD_WB, RD_TX, STATUS_TX; transitions as REQ-011..REQ-016.
REQ-011 Write: each data byte SHALL raise cyc_o/stb_o with we_o=1 on the cycle after the byte's stop-bit sample; beat i uses adr_o = base+i, wrapping modulo 2^ADDR_WIDTH.
REQ-012 Read: after the last address byte, cyc_o/stb_o rise next cycle with we_o=0; on termination dat_i (or 0x00 if err_i/rty_i/timeout) is latched and transmitted; the next beat starts the cycle after that byte's stop bit completes.
REQ-013 cyc_o SHALL drop on the cycle after any of ack_i/err_i/rty_i; priority err_i > rty_i > ack_i when several are high together.
REQ-014 If no termination within TIMEOUT_CYCLES, cyc_o SHALL drop and the beat SHALL count as a timeout.
REQ-015 adr_o, we_o and dat_o SHALL be stable while cyc_o is high.
REQ-016 Transmitter: start bit, 8 data bits, stop bit, each CLKS_PER_BIT cycles; uart_txd idles high.
REQ-017 Bytes received during RD_WB/RD_TX SHALL be discarded (host must not send during read replies).

Reset
REQ-018 On rst_i: uart_txd=1, cyc_o=stb_o=0, we_o=0, adr_o=0, dat_o=0, parser IDLE, receiver idle, counters 0.
REQ-019 rst_i asserted mid-cycle or mid-byte SHALL drop cyc_o and uart_txd returns high on the next edge; partial frames lost.

Configuration
REQ-020 Macro UART_WB_STATUS_EN defined: a STATUS_TX byte follows every command (0x00 ack, 0x01 err, 0x02 rty, 0x03 timeout), and the first non-ack beat aborts the remaining burst; remaining write data bytes are discarded until N have arrived.
REQ-021 UART_WB_STATUS_EN undefined: no abort, no status byte on reads; each write command returns a single 0x00 after the last beat.

Verification
REQ-022 Write N=1, addr 0x000123, data 0xA5, ack after 2 cycles -> one WB write adr_o=0x000123 dat_o=0xA5, then tx 0x00.
REQ-023 Read N=3, addr 0x7FFFFF, slave returns 0x11,0x22,0x33 -> adr_o 0x7FFFFF,0x000000,0x000001; tx 0x11,0x22,0x33 (+0x00 with STATUS_EN).
REQ-024 Write N=2 with err_i on beat 0 under STATUS_EN -> one WB cycle only, tx 0x01; without macro -> two cycles, tx 0x00.
REQ-025 Read N=1, slave never terminates -> cyc_o high exactly 64 cycles, tx 0x00 (then 0x03 with STATUS_EN).
REQ-026 CMD byte with stop bit forced low, then valid frame -> first ignored, second executes normally; 2-cycle rxd glitch in IDLE -> no byte received.
REQ-027 rst_i pulsed while cyc_o high -> cyc_o low next edge, uart_txd=1, next full frame executes correctly.
